pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
- Carries a generic control-plus-data payload between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer lets upstream ready be registered, which breaks the combinational stall path while giving full throughput.
- Supports flush, a legacy stall input, and an occupancy output, so every stage boundary can instantiate one block.

Parameters:
- DATA_WIDTH, 32: width of the data payload (ALU result, store data, etc.).
- CTRL_WIDTH, 8: width of the control payload (mem valid, mask, R/W, writeback enable, write address). Always zeroed on flush and on reset.
- CLEAR_DATA_ON_FLUSH, 1: 1 = data fields are zeroed on flush; 0 = data fields hold their values on flush (saves power, since validity is carried by o_Valid).

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Reset  in  1  reset. One clock; reset is synchronous and active-high.
- i_Flush  in  1  discard all held and incoming entries.
- i_Stall  in  1  legacy stall; treated as downstream not ready.
- i_Valid  in  1  upstream entry present.
- o_Ready  out  1  stage can accept an entry this cycle; registered.
- i_Ctrl  in  CTRL_WIDTH  upstream control payload.
- i_Data  in  DATA_WIDTH  upstream data payload.
- o_Valid  out  1  output entry present.
- i_Ready  in  1  downstream accepts the output entry.
- o_Ctrl  out  CTRL_WIDTH  output control payload.
- o_Data  out  DATA_WIDTH  output data payload.
- o_Count  out  2  entries held (0..2).

Behaviour:
- Storage: main register M (drives the outputs) and skid register S, each with a valid bit.
- Reset: applied at the clock edge while i_Reset=1. It overrides flush and handshake.
  - M.valid=0, S.valid=0.
  - o_Ctrl=0, o_Data=0, o_Count=0.
  - o_Ready=1 in the first cycle after reset.
  - Reset mid-transfer drops all entries with no partial state.
- Transfer conditions:
  - in_fire = i_Valid & o_Ready.
  - out_fire = o_Valid & i_Ready & !i_Stall.
- Outputs: o_Valid = M.valid. o_Ctrl/o_Data = M payload. o_Ready = !S.valid, registered with no combinational path from i_Ready or i_Stall.
- Latency: 1 cycle from in_fire to o_Valid when empty. Throughput: 1 entry per cycle when downstream is always ready.
- States, by (M.valid, S.valid):
  - EMPTY (0,0): in_fire loads M, then FULL1.
  - FULL1 (1,0):
    - in_fire & out_fire: new entry loads M; stay FULL1.
    - in_fire & !out_fire: new entry loads S; go to FULL2.
    - !in_fire & out_fire: go to EMPTY.
  - FULL2 (1,1): o_Ready=0, so in_fire is impossible.
    - out_fire: S moves to M, S clears; go to FULL1.
    - Otherwise hold.
- Ordering: strict FIFO. The S entry never overtakes the M entry.
- Flush (i_Reset=0, i_Flush=1):
  - Both valid bits clear, o_Count=0, next state EMPTY.
  - Ctrl fields of M and S are zeroed. Data fields are zeroed only if CLEAR_DATA_ON_FLUSH=1.
  - An input presented in the flush cycle is dropped, even if in_fire=1.
  - A simultaneous out_fire still completes downstream; the entry leaves and is not duplicated.
  - Flush wins over i_Stall.
- Stall: i_Stall=1 blocks out_fire only. Upstream may still fill S while o_Ready=1.
- o_Count: 0/1/2 for EMPTY/FULL1/FULL2. Registered, updated the same edge as the valid bits.
- Payload registers load only on their load condition; otherwise they hold.
- Invariant: no X on outputs after the first reset edge.

Test Plan:
- Pass-through: i_Ready=1, i_Valid=1 with data 0x11,0x22,0x33 on consecutive cycles -> o_Data equals 0x11,0x22,0x33 one cycle later each; o_Ready stays 1; o_Count stays 1.
- Backpressure: drive 0xA0,0xA1 while i_Ready=0 -> o_Count=2, o_Ready=0 next cycle, o_Data=0xA0. Then raise i_Ready -> o_Data 0xA0 then 0xA1, o_Ready returns to 1, no entry lost or duplicated.
- Stall: FULL1 holding 0x55, i_Stall=1, i_Ready=1 for 3 cycles -> o_Data holds 0x55, o_Valid=1. Deassert stall -> 0x55 is consumed once.
- Flush: FULL2 holding 0xB0,0xB1, i_Flush=1 with i_Valid=1, i_Data=0xB2 -> next cycle o_Valid=0, o_Count=0, o_Ctrl=0, o_Data=0 (CLEAR_DATA_ON_FLUSH=1). 0xB2 never appears on the output.
- Reset mid-operation: FULL2 state, i_Reset=1 for one edge -> all outputs 0, o_Ready=1. The next accepted entry 0xC0 appears 1 cycle after acceptance.
- Parameter sweep: DATA_WIDTH=64, CTRL_WIDTH=3, CLEAR_DATA_ON_FLUSH=0, flush while holding 0xDEADBEEF_CAFEF00D -> o_Valid=0, o_Ctrl=0, o_Data holds 0xDEADBEEF_CAFEF00D.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: a 2-entry skid buffer between two pipeline stages.
// The main register M drives the outputs and the skid register S absorbs the
// one entry that can arrive in the cycle downstream stops accepting. Because
// of that, o_Ready is a plain flop and does not depend combinationally on
// i_Ready or i_Stall, yet the stage still moves one entry per cycle.
module pipe_stage_elastic #(
  parameter int DATA_WIDTH          = 32,
  parameter int CTRL_WIDTH          = 8,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Flush,
  input  logic                  i_Stall,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  input  logic [CTRL_WIDTH-1:0] i_Ctrl,
  input  logic [DATA_WIDTH-1:0] i_Data,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic [CTRL_WIDTH-1:0] o_Ctrl,
  output logic [DATA_WIDTH-1:0] o_Data,
  output logic [1:0]            o_Count
);

  // State encoding: bit 0 is the M valid bit, bit 1 is the S valid bit.
  // S is only ever valid while M is valid, so 2'b10 cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b01,
    FULL2 = 2'b11
  } state_t;

  state_t                state_reg;
  logic                  ready_reg;
  logic [1:0]            count_reg;
  logic [CTRL_WIDTH-1:0] m_ctrl_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;
  logic [CTRL_WIDTH-1:0] s_ctrl_reg;
  logic [DATA_WIDTH-1:0] s_data_reg;

  logic in_fire;
  logic out_fire;

  // Handshake qualifiers; a legacy stall looks like downstream not ready.
  assign in_fire  = i_Valid & ready_reg;
  assign out_fire = state_reg[0] & i_Ready & ~i_Stall;

  // Occupancy FSM plus payload registers; every output comes from a flop.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg  <= EMPTY;
      ready_reg  <= 1'b1;
      count_reg  <= 2'd0;
      m_ctrl_reg <= '0;
      m_data_reg <= '0;
      s_ctrl_reg <= '0;
      s_data_reg <= '0;
    end else if (i_Flush) begin
      // Drop everything held plus whatever is offered this cycle. An entry
      // leaving on out_fire has already been seen downstream, so clearing M
      // cannot duplicate it.
      state_reg  <= EMPTY;
      ready_reg  <= 1'b1;
      count_reg  <= 2'd0;
      m_ctrl_reg <= '0;
      s_ctrl_reg <= '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        m_data_reg <= '0;
        s_data_reg <= '0;
      end
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            m_ctrl_reg <= i_Ctrl;
            m_data_reg <= i_Data;
            state_reg  <= FULL1;
            count_reg  <= 2'd1;
          end
        end
        FULL1: begin
          if (in_fire && out_fire) begin
            // M drains and refills in the same edge.
            m_ctrl_reg <= i_Ctrl;
            m_data_reg <= i_Data;
          end else if (in_fire) begin
            // Downstream is blocked: park the new entry behind M.
            s_ctrl_reg <= i_Ctrl;
            s_data_reg <= i_Data;
            state_reg  <= FULL2;
            count_reg  <= 2'd2;
            ready_reg  <= 1'b0;
          end else if (out_fire) begin
            state_reg  <= EMPTY;
            count_reg  <= 2'd0;
          end
        end
        FULL2: begin
          // Ready is low here, so only the drain side can move. S keeps its
          // stale payload once promoted; its valid bit lives in state_reg.
          if (out_fire) begin
            m_ctrl_reg <= s_ctrl_reg;
            m_data_reg <= s_data_reg;
            state_reg  <= FULL1;
            count_reg  <= 2'd1;
            ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= EMPTY;
          count_reg <= 2'd0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign o_Valid = state_reg[0];
  assign o_Ready = ready_reg;
  assign o_Count = count_reg;
  assign o_Ctrl  = m_ctrl_reg;
  assign o_Data  = m_data_reg;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a vector table for the default
// configuration plus a short hand sequence for a 64-bit, hold-data-on-flush
// configuration.
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration DUT signals.
  logic        rst, flush, stall, valid, ready;
  logic [7:0]  ctrl;
  logic [31:0] data;
  logic        o_valid, o_ready;
  logic [7:0]  o_ctrl;
  logic [31:0] o_data;
  logic [1:0]  o_count;

  // Wide configuration DUT signals.
  logic        r64, f64, s64, v64, rd64;
  logic [2:0]  c64;
  logic [63:0] d64;
  logic        ov64, or64;
  logic [2:0]  oc64;
  logic [63:0] od64;
  logic [1:0]  on64;

  int total = 0;
  int bad   = 0;

  pipe_stage_elastic dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .i_Flush (flush),
    .i_Stall (stall),
    .i_Valid (valid),
    .o_Ready (o_ready),
    .i_Ctrl  (ctrl),
    .i_Data  (data),
    .o_Valid (o_valid),
    .i_Ready (ready),
    .o_Ctrl  (o_ctrl),
    .o_Data  (o_data),
    .o_Count (o_count)
  );

  pipe_stage_elastic #(
    .DATA_WIDTH          (64),
    .CTRL_WIDTH          (3),
    .CLEAR_DATA_ON_FLUSH (1'b0)
  ) dut64 (
    .i_Clk   (clk),
    .i_Reset (r64),
    .i_Flush (f64),
    .i_Stall (s64),
    .i_Valid (v64),
    .o_Ready (or64),
    .i_Ctrl  (c64),
    .i_Data  (d64),
    .o_Valid (ov64),
    .i_Ready (rd64),
    .o_Ctrl  (oc64),
    .o_Data  (od64),
    .o_Count (on64)
  );

  typedef struct {
    logic        rst, flush, stall, valid, ready;
    logic [7:0]  ctrl;
    logic [31:0] data;
    logic        e_valid, e_ready;
    logic [1:0]  e_count;
    logic [7:0]  e_ctrl;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, f, s, v, rd, input logic [7:0] c,
                     input logic [31:0] d, input logic ev, er,
                     input logic [1:0] ec, input logic [7:0] ectl,
                     input logic [31:0] ed);
    vec_t t;
    t.rst = r; t.flush = f; t.stall = s; t.valid = v; t.ready = rd;
    t.ctrl = c; t.data = d;
    t.e_valid = ev; t.e_ready = er; t.e_count = ec;
    t.e_ctrl = ectl; t.e_data = ed;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; valid = 1'b0; ready = 1'b1;
    ctrl = '0; data = '0;
    r64 = 1'b1; f64 = 1'b0; s64 = 1'b0; v64 = 1'b0; rd64 = 1'b0;
    c64 = '0; d64 = '0;

    //   rst fl st va rd ctrl   data    | ev er cnt ctrl   data
    add(1, 0, 0, 0, 1, 8'h00, 32'h00,   0, 1, 0, 8'h00, 32'h00); // reset
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   0, 1, 0, 8'h00, 32'h00); // idle
    add(0, 0, 0, 1, 1, 8'h01, 32'h11,   1, 1, 1, 8'h01, 32'h11); // pass-through
    add(0, 0, 0, 1, 1, 8'h02, 32'h22,   1, 1, 1, 8'h02, 32'h22);
    add(0, 0, 0, 1, 1, 8'h03, 32'h33,   1, 1, 1, 8'h03, 32'h33);
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   0, 1, 0, 8'h03, 32'h33); // drain, payload holds
    add(0, 0, 0, 1, 0, 8'h10, 32'hA0,   1, 1, 1, 8'h10, 32'hA0); // backpressure
    add(0, 0, 0, 1, 0, 8'h11, 32'hA1,   1, 0, 2, 8'h10, 32'hA0);
    add(0, 0, 0, 1, 0, 8'h12, 32'hA2,   1, 0, 2, 8'h10, 32'hA0); // not accepted
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   1, 1, 1, 8'h11, 32'hA1); // A0 out, A1 promoted
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   0, 1, 0, 8'h11, 32'hA1);
    add(0, 0, 0, 1, 1, 8'h20, 32'h55,   1, 1, 1, 8'h20, 32'h55); // stall
    add(0, 0, 1, 0, 1, 8'h00, 32'h00,   1, 1, 1, 8'h20, 32'h55);
    add(0, 0, 1, 0, 1, 8'h00, 32'h00,   1, 1, 1, 8'h20, 32'h55);
    add(0, 0, 1, 0, 1, 8'h00, 32'h00,   1, 1, 1, 8'h20, 32'h55);
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   0, 1, 0, 8'h20, 32'h55); // consumed once
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   0, 1, 0, 8'h20, 32'h55);
    add(0, 0, 1, 1, 1, 8'h21, 32'h66,   1, 1, 1, 8'h21, 32'h66); // stall fills S
    add(0, 0, 1, 1, 1, 8'h22, 32'h67,   1, 0, 2, 8'h21, 32'h66);
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   1, 1, 1, 8'h22, 32'h67);
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   0, 1, 0, 8'h22, 32'h67);
    add(0, 0, 0, 1, 0, 8'h30, 32'hB0,   1, 1, 1, 8'h30, 32'hB0); // flush from FULL2
    add(0, 0, 0, 1, 0, 8'h31, 32'hB1,   1, 0, 2, 8'h30, 32'hB0);
    add(0, 1, 0, 1, 0, 8'h32, 32'hB2,   0, 1, 0, 8'h00, 32'h00);
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   0, 1, 0, 8'h00, 32'h00); // B2 never shows
    add(0, 0, 0, 1, 1, 8'h40, 32'hD0,   1, 1, 1, 8'h40, 32'hD0); // flush with in+out fire
    add(0, 1, 0, 1, 1, 8'h41, 32'hD1,   0, 1, 0, 8'h00, 32'h00);
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   0, 1, 0, 8'h00, 32'h00);
    add(0, 0, 0, 1, 0, 8'h50, 32'hC8,   1, 1, 1, 8'h50, 32'hC8); // reset from FULL2
    add(0, 0, 0, 1, 0, 8'h51, 32'hC9,   1, 0, 2, 8'h50, 32'hC8);
    add(1, 0, 0, 1, 0, 8'h52, 32'hCA,   0, 1, 0, 8'h00, 32'h00);
    add(0, 0, 0, 1, 0, 8'h60, 32'hC0,   1, 1, 1, 8'h60, 32'hC0); // 1-cycle latency
    add(0, 0, 0, 0, 1, 8'h00, 32'h00,   0, 1, 0, 8'h60, 32'hC0);
    add(1, 1, 0, 1, 1, 8'h70, 32'h77,   0, 1, 0, 8'h00, 32'h00); // reset beats flush

    // Reset both instances together and check the wide one's reset state.
    tick();
    chk("w64_rst_valid", -1, 64'(ov64), 64'd0);
    chk("w64_rst_ready", -1, 64'(or64), 64'd1);
    chk("w64_rst_data",  -1, od64,      64'd0);
    chk("w64_rst_ctrl",  -1, 64'(oc64), 64'd0);
    chk("w64_rst_count", -1, 64'(on64), 64'd0);
    r64 = 1'b0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; flush = vecs[i].flush; stall = vecs[i].stall;
      valid = vecs[i].valid; ready = vecs[i].ready;
      ctrl = vecs[i].ctrl; data = vecs[i].data;
      tick();
      $display("step %0d: v=%0b r=%0b cnt=%0d ctrl=%h data=%h", i,
               o_valid, o_ready, o_count, o_ctrl, o_data);
      chk("valid", i, 64'(o_valid), 64'(vecs[i].e_valid));
      chk("ready", i, 64'(o_ready), 64'(vecs[i].e_ready));
      chk("count", i, 64'(o_count), 64'(vecs[i].e_count));
      chk("ctrl",  i, 64'(o_ctrl),  64'(vecs[i].e_ctrl));
      chk("data",  i, 64'(o_data),  64'(vecs[i].e_data));
    end

    // Wide instance: load one entry, then flush with data held.
    v64 = 1'b1; c64 = 3'b101; d64 = 64'hDEADBEEF_CAFEF00D; rd64 = 1'b0;
    tick();
    $display("w64 load: v=%0b cnt=%0d ctrl=%h data=%h", ov64, on64, oc64, od64);
    chk("w64_load_valid", 100, 64'(ov64), 64'd1);
    chk("w64_load_ctrl",  100, 64'(oc64), 64'd5);
    chk("w64_load_data",  100, od64,      64'hDEADBEEF_CAFEF00D);
    f64 = 1'b1; c64 = 3'b011; d64 = 64'h0123_4567_89AB_CDEF;
    tick();
    $display("w64 flush: v=%0b cnt=%0d ctrl=%h data=%h", ov64, on64, oc64, od64);
    chk("w64_flush_valid", 101, 64'(ov64), 64'd0);
    chk("w64_flush_ctrl",  101, 64'(oc64), 64'd0);
    chk("w64_flush_count", 101, 64'(on64), 64'd0);
    chk("w64_flush_ready", 101, 64'(or64), 64'd1);
    chk("w64_flush_data",  101, od64,      64'hDEADBEEF_CAFEF00D);
    f64 = 1'b0; v64 = 1'b0; rd64 = 1'b1;
    tick();
    $display("w64 idle: v=%0b cnt=%0d ctrl=%h data=%h", ov64, on64, oc64, od64);
    chk("w64_idle_valid", 102, 64'(ov64), 64'd0);
    chk("w64_idle_data",  102, od64,      64'hDEADBEEF_CAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
